// File: rtl/timer_arb_pkg.sv
// Shared definitions for the timer request arbiter: FSM states, timer
// register map and control-word encodings.
package timer_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_WAIT_IRQ, S_CLR, S_STOP, S_DONE
  } state_e;

  // Timer slave register indices
  localparam logic [2:0] TMR_ADDR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_ADDR_PERIOD_H = 3'd3;

  // Control register bit positions
  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  localparam logic [15:0] CTRL_START_ONESHOT = 16'h0005;
  localparam logic [15:0] CTRL_STOP          = 16'h0008;

  // A zero period would never time out; the shortest real delay is one tick.
  function automatic logic [31:0] promote_ticks(input logic [31:0] t);
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

endpackage

// File: rtl/timer_arb_pick.sv
// Combinational winner select. With TIMER_ARB_RR_EN defined the search
// begins at 'start' and wraps; otherwise the lowest requesting index wins.
module timer_arb_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
`ifdef TIMER_ARB_RR_EN
  input  logic [2:0]       start,
`endif
  output logic [2:0]       idx,
  output logic             vld
);

  // Two passes for round-robin: indices at/after start, then wrap to lowest.
  always_comb begin
    idx = '0;
    vld = 1'b0;
`ifdef TIMER_ARB_RR_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (!vld && req[i] && (3'(i) >= start)) begin
        idx = 3'(i);
        vld = 1'b1;
      end
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (!vld && req[i]) begin
        idx = 3'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_req_arbiter.sv
// Shares one interval timer between N_REQ one-shot delay requesters.
// Programs period, starts one-shot with irq, waits for irq (or withdrawal),
// clears the timeout and pulses done to the winner.
// Optional feature macro: TIMER_ARB_RR_EN (round-robin arbitration).
module timer_req_arbiter
  import timer_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TICKS_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*TICKS_W-1:0] req_ticks,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [2:0]               grant_id,
  output logic                     tmr_chipselect,
  output logic                     tmr_write_n,
  output logic [2:0]               tmr_address,
  output logic [15:0]              tmr_writedata,
  input  logic                     tmr_irq
);

  state_e             state_q, state_d;
  logic [TICKS_W-1:0] ticks_q, ticks_d;
  logic               stopped_q, stopped_d;
  logic [2:0]         grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               cs_q, cs_d;
  logic               wr_n_q, wr_n_d;
  logic [2:0]         addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;

  logic [2:0]         pick_idx;
  logic               pick_vld;
  logic [TICKS_W-1:0] sel_ticks;
  logic               cur_req;

`ifdef TIMER_ARB_RR_EN
  logic [2:0] rr_ptr_q, rr_ptr_d;
`endif

  timer_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
`ifdef TIMER_ARB_RR_EN
    .start (rr_ptr_q),
`endif
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  // Mux the winner's tick slice and the granted requester's live request.
  always_comb begin
    sel_ticks = '0;
    cur_req   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == 3'(i)) sel_ticks = req_ticks[i*TICKS_W +: TICKS_W];
      if (grant_q == 3'(i))  cur_req   = req[i];
    end
  end

  // Next state; bus outputs are computed for the state being entered so
  // each write appears registered in the cycle that state is occupied.
  always_comb begin
    state_d   = state_q;
    ticks_d   = ticks_q;
    stopped_d = stopped_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    done_d    = '0;
    cs_d      = 1'b0;
    wr_n_d    = 1'b1;
    addr_d    = '0;
    wdata_d   = '0;
`ifdef TIMER_ARB_RR_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          ticks_d   = promote_ticks(sel_ticks);
          grant_d   = pick_idx;
          busy_d    = 1'b1;
          stopped_d = 1'b0;
`ifdef TIMER_ARB_RR_EN
          rr_ptr_d  = (pick_idx == 3'(N_REQ-1)) ? 3'd0 : pick_idx + 3'd1;
`endif
          cs_d      = 1'b1;
          wr_n_d    = 1'b0;
          addr_d    = TMR_ADDR_PERIOD_L;
          wdata_d   = ticks_d[15:0];
          state_d   = S_WR_PL;
        end
      end
      S_WR_PL: begin
        cs_d    = 1'b1;
        wr_n_d  = 1'b0;
        addr_d  = TMR_ADDR_PERIOD_H;
        wdata_d = ticks_q[31:16];
        state_d = S_WR_PH;
      end
      S_WR_PH: begin
        cs_d    = 1'b1;
        wr_n_d  = 1'b0;
        addr_d  = TMR_ADDR_CONTROL;
        wdata_d = CTRL_START_ONESHOT;
        state_d = S_WR_CTRL;
      end
      S_WR_CTRL: state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        // irq takes precedence over a simultaneous withdrawal
        if (tmr_irq) begin
          cs_d    = 1'b1;
          wr_n_d  = 1'b0;
          addr_d  = TMR_ADDR_STATUS;
          state_d = S_CLR;
        end else if (!cur_req) begin
          cs_d    = 1'b1;
          wr_n_d  = 1'b0;
          addr_d  = TMR_ADDR_CONTROL;
          wdata_d = CTRL_STOP;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cs_d      = 1'b1;
        wr_n_d    = 1'b0;
        addr_d    = TMR_ADDR_STATUS;
        stopped_d = 1'b1;
        state_d   = S_CLR;
      end
      S_CLR: begin
        if (stopped_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < N_REQ; i++) done_d[i] = (grant_q == 3'(i));
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ticks_q   <= '0;
      stopped_q <= 1'b0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      cs_q      <= 1'b0;
      wr_n_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef TIMER_ARB_RR_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ticks_q   <= ticks_d;
      stopped_q <= stopped_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      wr_n_q    <= wr_n_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
`ifdef TIMER_ARB_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign done           = done_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wr_n_q;
  assign tmr_address    = addr_q;
  assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_req_arbiter.sv
// Scoreboard bench for timer_req_arbiter: stimulus pushes the expected bus
// writes / done pulses, a negedge monitor pops and compares.
module tb_timer_req_arbiter;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*32-1:0]  req_ticks = '0;
  logic [N-1:0]     done;
  logic             busy;
  logic [2:0]       grant_id;
  logic             tmr_chipselect;
  logic             tmr_write_n;
  logic [2:0]       tmr_address;
  logic [15:0]      tmr_writedata;
  logic             tmr_irq = 1'b0;

  timer_req_arbiter #(.N_REQ(N), .TICKS_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_ticks      (req_ticks),
    .done           (done),
    .busy           (busy),
    .grant_id       (grant_id),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_address    (tmr_address),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [N-1:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rr_start = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.data = d; e.mask = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int w);
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0; e.mask = '0;
    e.mask[w] = 1'b1;
    exp_q.push_back(e);
  endtask

  // Reference arbitration rule
  function automatic int model_pick(input logic [N-1:0] m);
`ifdef TIMER_ARB_RR_EN
    for (int k = 0; k < N; k++) if (m[(rr_start + k) % N]) return (rr_start + k) % N;
`else
    for (int i = 0; i < N; i++) if (m[i]) return i;
`endif
    return -1;
  endfunction

  // Monitor: every bus write and every done pulse must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tmr_chipselect) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          chk("unexpected_write", {26'd0, tmr_address, 3'd0}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(tmr_address), 32'(e.addr));
          chk("wr_data", 32'(tmr_writedata), 32'(e.data));
          chk("wr_n", 32'(tmr_write_n), 32'd0);
        end
      end
      if (done != '0) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_mask", 32'(done), 32'(e.mask));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant"}, 32'(grant_id), 32'd0);
    chk({tag, "_cs"}, 32'(tmr_chipselect), 32'd0);
    chk({tag, "_wr_n"}, 32'(tmr_write_n), 32'd1);
    chk({tag, "_addr"}, 32'(tmr_address), 32'd0);
    chk({tag, "_wdata"}, 32'(tmr_writedata), 32'd0);
  endtask

  // scen: 0 = irq, 1 = withdraw, 2 = withdraw and irq in the same cycle
  task automatic run_round(input logic [N-1:0] mask, input logic [N*32-1:0] tv,
                           input int scen, input int extra);
    int w;
    logic [31:0] t;
    @(negedge clk);
    req_ticks = tv;
    req = mask;
    w = model_pick(mask);
    t = tv[w*32 +: 32];
    if (t == 32'd0) t = 32'd1;
    push_wr(3'd2, t[15:0]);
    push_wr(3'd3, t[31:16]);
    push_wr(3'd1, 16'h0005);
    if (scen == 1) begin
      push_wr(3'd1, 16'h0008);
      push_wr(3'd0, 16'h0000);
    end else begin
      push_wr(3'd0, 16'h0000);
      push_done(w);
    end
    @(posedge clk); #1;
    chk("wr_pl_latency", {31'd0, tmr_chipselect}, 32'd1);
    chk("busy_granted", 32'(busy), 32'd1);
    repeat (3 + extra) @(posedge clk);
    @(negedge clk);
    if (scen != 1) tmr_irq = 1'b1;
    if (scen != 0) req[w] = 1'b0;
    @(negedge clk);
    tmr_irq = 1'b0;
    req = '0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk("busy_falls", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
    chk("grant_id", 32'(grant_id), 32'(w));
    rr_start = (w + 1) % N;
  endtask

  initial begin
    logic [N*32-1:0] tv;
    logic [31:0] t;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Directed: single req[0], 100000 ticks, normal irq completion
    tv = '0; tv[31:0] = 32'h0001_86A0;
    run_round(3'b001, tv, 0, 2);
    // Two requesters together, two rounds each re-raising both
    tv = {32'd7, 32'd500, 32'd300};
    run_round(3'b011, tv, 0, 1);
    run_round(3'b011, tv, 0, 0);
    run_round(3'b011, tv, 0, 3);
    run_round(3'b011, tv, 0, 1);
    // Zero ticks promoted to one
    tv = '0;
    run_round(3'b001, tv, 0, 0);
    // Withdrawal of req[1] during wait
    tv = {32'd0, 32'h1234_5678, 32'd0};
    run_round(3'b010, tv, 1, 4);
    // Withdrawal and irq in the same cycle: irq wins
    run_round(3'b100, {32'h00AB_CDEF, 64'd0}, 2, 2);

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        t = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        tv[i*32 +: 32] = t;
      end
      run_round(3'($urandom_range(1, (1 << N) - 1)), tv, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 6)));
    end

    // Reset while waiting for irq; later irq must be ignored
    @(negedge clk);
    tv = '0; tv[63:32] = 32'h0002_0003;
    req_ticks = tv;
    req = 3'b010;
    push_wr(3'd2, 16'h0003);
    push_wr(3'd3, 16'h0002);
    push_wr(3'd1, 16'h0005);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    req = '0;
    rr_start = 0;
    tmr_irq = 1'b1;
    repeat (2) @(negedge clk);
    tmr_irq = 1'b0;
    repeat (6) @(negedge clk);
    chk("midreset_no_activity", 32'(exp_q.size()), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
